// File: rtl/lcd_text_ctrl_if.sv
// Requester/LCD-side signal bundle for the character LCD text controller.
// The master side is the character source plus the LCD interface; the slave side is the controller.
interface lcd_text_ctrl_if;
    logic       char_valid;
    logic [7:0] char_data;
    logic       char_ready;
    logic       clr_req;
    logic       lcd_busy;
    logic       lcd_enable;
    logic [9:0] lcd_bus;
    logic [5:0] col;
    logic       row;
    logic       idle;

    modport master (
        output char_valid, char_data, clr_req, lcd_busy,
        input  char_ready, lcd_enable, lcd_bus, col, row, idle
    );

    modport slave (
        input  char_valid, char_data, clr_req, lcd_busy,
        output char_ready, lcd_enable, lcd_bus, col, row, idle
    );
endinterface

// File: rtl/lcd_text_ctrl.sv
// Two-row character LCD text controller: accepts bytes, tracks the cursor, issues
// character/address/clear transfers with a fixed inter-transfer gap and busy drain.
module lcd_text_ctrl #(
    parameter int COLS        = 16,
    parameter int XFER_CYCLES = 52
) (
    input  logic            clk,
    input  logic            rst,
    lcd_text_ctrl_if.slave  ctrl
);
    typedef enum logic [2:0] {WAIT_INIT, IDLE, ISSUE, GAP, DRAIN} state_t;

    localparam logic [5:0] COLS_W   = 6'(COLS);
    localparam logic [7:0] GAP_LOAD = 8'(XFER_CYCLES - 2);

    state_t     state;
    logic       clr_pend;
    logic       addr_pend;
    logic       init_seen;
    logic [7:0] gap_cnt;
    logic       enable_q;
    logic [9:0] bus_q;
    logic [5:0] col_q;
    logic       row_q;

    // DDRAM set-address command for the start of the given row.
    function automatic logic [9:0] addr_cmd(input logic row_new);
        return {2'b00, 8'h80 | (row_new ? 8'h40 : 8'h00)};
    endfunction

    assign ctrl.char_ready = (state == IDLE) & ~ctrl.clr_req & ~clr_pend;
    assign ctrl.idle       = (state == IDLE) & ~clr_pend;
    assign ctrl.lcd_enable = enable_q;
    assign ctrl.lcd_bus    = bus_q;
    assign ctrl.col        = col_q;
    assign ctrl.row        = row_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= WAIT_INIT;
            clr_pend  <= 1'b0;
            addr_pend <= 1'b0;
            init_seen <= 1'b0;
            gap_cnt   <= '0;
            enable_q  <= 1'b0;
            bus_q     <= '0;
            col_q     <= '0;
            row_q     <= 1'b0;
        end else begin
            enable_q <= 1'b0;
            // Clears requested while busy are remembered; repeats collapse into one.
            if (ctrl.clr_req && state != IDLE)
                clr_pend <= 1'b1;

            case (state)
                WAIT_INIT: begin
                    if (!ctrl.lcd_busy) begin
                        if (init_seen) begin
                            state     <= IDLE;
                            init_seen <= 1'b0;
                        end else begin
                            init_seen <= 1'b1;
                        end
                    end else begin
                        init_seen <= 1'b0;
                    end
                end
                IDLE: begin
                    if (ctrl.clr_req || clr_pend) begin
                        clr_pend <= 1'b0;
                        bus_q    <= 10'h001;
                        col_q    <= '0;
                        row_q    <= 1'b0;
                        enable_q <= 1'b1;
                        state    <= ISSUE;
                    end else if (ctrl.char_valid) begin
                        enable_q <= 1'b1;
                        state    <= ISSUE;
                        if (ctrl.char_data == 8'h0A) begin
                            bus_q <= addr_cmd(~row_q);
                            row_q <= ~row_q;
                            col_q <= '0;
                        end else begin
                            // Column may briefly read COLS until the address step wraps it.
                            bus_q     <= {2'b10, ctrl.char_data};
                            col_q     <= col_q + 6'd1;
                            addr_pend <= (col_q + 6'd1 == COLS_W);
                        end
                    end
                end
                ISSUE: begin
                    gap_cnt <= GAP_LOAD;
                    state   <= GAP;
                end
                GAP: begin
                    if (gap_cnt == 8'd0)
                        state <= DRAIN;
                    else
                        gap_cnt <= gap_cnt - 8'd1;
                end
                DRAIN: begin
                    if (!ctrl.lcd_busy) begin
                        if (addr_pend) begin
                            addr_pend <= 1'b0;
                            bus_q     <= addr_cmd(~row_q);
                            row_q     <= ~row_q;
                            col_q     <= '0;
                            enable_q  <= 1'b1;
                            state     <= ISSUE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= WAIT_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Scoreboard bench for lcd_text_ctrl: a cursor-level model queues expected transfers,
// and an independent monitor checks every lcd_enable pulse against that queue.
module tb_lcd_text_ctrl;
    localparam int COLS = 16;
    localparam int XFER = 52;

    typedef struct packed {
        logic [9:0] bus;
        logic [5:0] col;
        logic       row;
    } pulse_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lcd_text_ctrl_if ifc();

    lcd_text_ctrl #(.COLS(COLS), .XFER_CYCLES(XFER)) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (ifc.slave)
    );

    pulse_t exp_q[$];
    int nvec = 0;
    int nerr = 0;
    int mcol = 0;
    int mrow = 0;
    int busy_mode = 1;   // 0: ready, 1: busy, 2: random

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cursor model: what the display should receive for each request.
    function automatic logic [9:0] row_addr(input int r);
        return (r != 0) ? 10'h0C0 : 10'h080;
    endfunction

    function automatic void m_clear();
        mcol = 0;
        mrow = 0;
        exp_q.push_back({10'h001, 6'd0, 1'b0});
    endfunction

    function automatic void m_char(input logic [7:0] b);
        pulse_t p;
        if (b == 8'h0A) begin
            mrow = 1 - mrow;
            mcol = 0;
            p = {row_addr(mrow), 6'd0, (mrow != 0)};
            exp_q.push_back(p);
        end else begin
            mcol = mcol + 1;
            p = {2'b10, b, 6'(mcol), (mrow != 0)};
            exp_q.push_back(p);
            if (mcol == COLS) begin
                mcol = 0;
                mrow = 1 - mrow;
                p = {row_addr(mrow), 6'd0, (mrow != 0)};
                exp_q.push_back(p);
            end
        end
    endfunction

    initial begin
        ifc.lcd_busy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (busy_mode)
                0:       ifc.lcd_busy = 1'b0;
                1:       ifc.lcd_busy = 1'b1;
                default: ifc.lcd_busy = ($urandom_range(0, 2) == 0);
            endcase
        end
    end

    logic prev_en = 1'b0;
    always @(negedge clk) begin
        pulse_t e;
        if (rst && ifc.lcd_enable) begin
            check("enable_width", {31'd0, prev_en}, 32'd0);
            if (exp_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_pulse: actual lcd_bus=%h col=%0d row=%0d required no pulse",
                         ifc.lcd_bus, ifc.col, ifc.row);
            end else begin
                e = exp_q.pop_front();
                check("pulse{bus,col,row}", {15'd0, ifc.lcd_bus, ifc.col, ifc.row}, {15'd0, e});
            end
        end
        prev_en = rst & ifc.lcd_enable;
    end

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (!ifc.idle && t < 3000) begin
            t++;
            @(negedge clk);
        end
        if (!ifc.idle) check("idle_timeout", {31'd0, ifc.idle}, 32'd1);
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        @(posedge clk);
        #1;
        ifc.char_valid = 1'b1;
        ifc.char_data  = b;
        m_char(b);
        @(negedge clk);
        while (!ifc.char_ready && t < 3000) begin
            t++;
            @(negedge clk);
        end
        if (!ifc.char_ready) check("accept_timeout", {31'd0, ifc.char_ready}, 32'd1);
        @(posedge clk);
        #1;
        ifc.char_valid = 1'b0;
        ifc.char_data  = 8'($urandom);
    endtask

    task automatic clear_pulse();
        @(posedge clk);
        #1;
        ifc.clr_req = 1'b1;
        @(posedge clk);
        #1;
        ifc.clr_req = 1'b0;
    endtask

    task automatic check_cursor(input string name, input int c, input int r);
        check(name, {25'd0, ifc.col, ifc.row}, {25'd0, 6'(c), (r != 0)});
    endtask

    initial begin
        logic [7:0] b;
        int op;
        int t;
        logic ready_seen;

        ifc.char_valid = 1'b0;
        ifc.char_data  = 8'h00;
        ifc.clr_req    = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_outputs", {13'd0, ifc.char_ready, ifc.lcd_enable, ifc.lcd_bus, ifc.col, ifc.row, ifc.idle},
              32'd0);

        // Busy held for 100 cycles after release, then dropped.
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_while_busy", {31'd0, ifc.idle}, 32'd0);
        busy_mode = 0;
        @(posedge clk);
        #2;
        @(negedge clk);
        @(negedge clk);
        check("idle_1_after_drop", {31'd0, ifc.idle}, 32'd0);
        @(negedge clk);
        check("idle_2_after_drop", {31'd0, ifc.idle}, 32'd1);

        // Single character and the ready-low window after its pulse.
        send(8'h41);
        t = 0;
        @(negedge clk);
        while (!ifc.lcd_enable && t < 10) begin
            t++;
            @(negedge clk);
        end
        check("pulse_seen", {31'd0, ifc.lcd_enable}, 32'd1);
        ready_seen = 1'b0;
        for (int i = 0; i < XFER; i++) begin
            ready_seen = ready_seen | ifc.char_ready;
            @(negedge clk);
        end
        check("ready_low_after_pulse", {31'd0, ready_seen}, 32'd0);
        wait_idle();
        check_cursor("cursor_after_41", 1, 0);

        // Row wrap after a full row, and back to row 0 after the second.
        wait_idle();
        m_clear();
        clear_pulse();
        for (int i = 0; i < COLS; i++) send(8'h30 + 8'(i));
        wait_idle();
        check_cursor("cursor_after_row0", 0, 1);
        for (int i = 0; i < COLS; i++) send(8'h61 + 8'(i));
        wait_idle();
        check_cursor("cursor_after_row1", 0, 0);

        // Newline from column 5.
        for (int i = 0; i < 5; i++) send(8'h20 + 8'(i));
        wait_idle();
        check_cursor("cursor_col5", 5, 0);
        send(8'h0A);
        wait_idle();
        check_cursor("cursor_after_nl", 0, 1);

        // Two clear pulses during a transfer collapse into one clear.
        send(8'h58);
        repeat (3) @(posedge clk);
        m_clear();
        clear_pulse();
        repeat (5) @(posedge clk);
        clear_pulse();
        wait_idle();
        check_cursor("cursor_after_merged_clear", 0, 0);

        // Simultaneous clear and character in IDLE: clear first.
        send(8'h44);
        wait_idle();
        @(posedge clk);
        #1;
        ifc.clr_req    = 1'b1;
        ifc.char_valid = 1'b1;
        ifc.char_data  = 8'h55;
        m_clear();
        m_char(8'h55);
        @(negedge clk);
        check("ready_during_clr", {31'd0, ifc.char_ready}, 32'd0);
        @(posedge clk);
        #1;
        ifc.clr_req = 1'b0;
        t = 0;
        @(negedge clk);
        while (!ifc.char_ready && t < 3000) begin
            t++;
            @(negedge clk);
        end
        check("accept_after_clear", {31'd0, ifc.char_ready}, 32'd1);
        @(posedge clk);
        #1;
        ifc.char_valid = 1'b0;
        ifc.char_data  = 8'hA5;
        wait_idle();
        check_cursor("cursor_after_clr_char", 1, 0);

        // Randomized traffic with a randomly busy LCD.
        busy_mode = 2;
        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 19);
            if (op == 0) begin
                wait_idle();
                m_clear();
                clear_pulse();
            end else if (op == 1) begin
                wait_idle();
                send(8'h0A);
                repeat (2) @(posedge clk);
                m_clear();
                clear_pulse();
                repeat ($urandom_range(1, 20)) @(posedge clk);
                clear_pulse();
            end else if (op < 4) begin
                send(8'h0A);
            end else begin
                b = 8'($urandom);
                if (b == 8'h0A) b = 8'h7E;
                send(b);
            end
        end
        wait_idle();
        check_cursor("cursor_after_random", mcol, mrow);

        // Reset during a transfer aborts it.
        busy_mode = 0;
        send(8'h33);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_mid_outputs", {13'd0, ifc.char_ready, ifc.lcd_enable, ifc.lcd_bus, ifc.col, ifc.row, ifc.idle},
              32'd0);
        exp_q.delete();
        mcol = 0;
        mrow = 0;
        ready_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            ready_seen = ready_seen | ifc.lcd_enable;
        end
        check("no_enable_in_reset", {31'd0, ready_seen}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        wait_idle();
        check_cursor("cursor_after_rst", 0, 0);
        send(8'h42);
        wait_idle();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL global_timeout: actual still running required finished");
        $fatal(1);
    end
endmodule
